// File: rtl/conv_pkg.sv
// Shared types and the requantize helper for the convolution writeback stage.
package conv_pkg;

  localparam int ACC_W_DEF  = 16;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;

  // Saturation bounds held at the widened (ACC_W+1) requantize width
  localparam logic signed [ACC_W_DEF:0] SAT_MAX = (ACC_W_DEF+1)'(2**(DATA_W_DEF-1) - 1);
  localparam logic signed [ACC_W_DEF:0] SAT_MIN = (ACC_W_DEF+1)'(-(2**(DATA_W_DEF-1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WR1,
    S_WR2,
    S_DONE
  } state_t;

  typedef struct packed {
    logic signed [ACC_W_DEF-1:0] sum1;
    logic signed [ACC_W_DEF-1:0] sum2;
    logic [ADDR_W_DEF-1:0]       addr1;
    logic [ADDR_W_DEF-1:0]       addr2;
    logic                        single;
  } pair_t;

  // Rounding arithmetic shift, optional ReLU, saturate to DATA_W.
  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [DATA_W_DEF-1:0] requant(
    input logic signed [ACC_W_DEF-1:0] sum,
    input logic [2:0]                  shift,
    input logic                        relu
  );
    logic signed [ACC_W_DEF:0] ext;
    logic signed [ACC_W_DEF:0] half;
    logic signed [ACC_W_DEF:0] rnd;
    ext  = {sum[ACC_W_DEF-1], sum};
    half = '0;
    rnd  = ext;
    if (shift != 3'd0) begin
      half = (ACC_W_DEF+1)'(1) << (shift - 3'd1);
      rnd  = (ext + half) >>> shift;
    end
    if (relu && rnd[ACC_W_DEF]) rnd = '0;
    if (rnd > SAT_MAX)      return SAT_MAX[DATA_W_DEF-1:0];
    else if (rnd < SAT_MIN) return SAT_MIN[DATA_W_DEF-1:0];
    else                    return rnd[DATA_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/conv_writeback_pair_fifo.sv
// Small synchronous FIFO of pair records with full/empty/count.
module pair_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  pair_t       din,
  output pair_t       head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  pair_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; no reset needed, occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_writeback.sv
// Requantizes accumulator pairs and serialises them onto one write port.
module conv_writeback
  import conv_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [9:0]        i_total_pairs,
  input  logic [2:0]        i_shift,
  input  logic              i_relu_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ACC_W-1:0]  i_sum1,
  input  logic [ACC_W-1:0]  i_sum2,
  input  logic [ADDR_W-1:0] i_dest_address1,
  input  logic [ADDR_W-1:0] i_dest_address2,
  input  logic              i_single,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [9:0]        total;
  logic [9:0]        accepted;
  logic [9:0]        written;
  logic [2:0]        shift;
  logic              relu;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  pair_t             din;
  pair_t             head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  logic              push;
  logic              pop;
  logic              wr_en;
  logic              last;
  logic              more;
  logic [ACC_W-1:0]  cur_sum;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;

  assign din = '{sum1: i_sum1, sum2: i_sum2, addr1: i_dest_address1,
                 addr2: i_dest_address2, single: i_single};

  pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Full blocks acceptance even when a pop is landing the same cycle
  assign o_ready = (state == S_WAIT || state == S_WR1 || state == S_WR2)
                   && !fifo_full && (accepted < total);
  assign push    = i_valid && o_ready;
  assign wr_en   = (state == S_WR1) || (state == S_WR2);
  assign pop     = (state == S_WR2) || (state == S_WR1 && head.single);
  assign last    = (written == total - 1'b1);
  // Something will sit at the FIFO head next cycle
  assign more    = push || (!fifo_empty && !(pop && fifo_count == CW'(1)));

  assign cur_sum  = (state == S_WR2) ? head.sum2  : head.sum1;
  assign cur_addr = (state == S_WR2) ? head.addr2 : head.addr1;
  assign cur_data = requant(cur_sum, shift, relu);

  assign o_wr_en   = wr_en;
  assign o_wr_addr = wr_en ? cur_addr : last_addr;
  assign o_wr_data = wr_en ? cur_data : last_data;
  assign o_busy    = (state != S_IDLE);
  assign o_done    = (state == S_DONE);

  // Job control FSM with accept/write counters and held write bus
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      total     <= '0;
      accepted  <= '0;
      written   <= '0;
      shift     <= '0;
      relu      <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (push) accepted <= accepted + 1'b1;
      if (wr_en) begin
        last_addr <= cur_addr;
        last_data <= cur_data;
      end
      case (state)
        S_IDLE: if (i_start) begin
          total    <= i_total_pairs;
          shift    <= i_shift;
          relu     <= i_relu_en;
          accepted <= '0;
          written  <= '0;
          state    <= (i_total_pairs == '0) ? S_DONE : S_WAIT;
        end
        // A pair landing this cycle is at the head next cycle
        S_WAIT: if (!fifo_empty || push) state <= S_WR1;
        S_WR1: begin
          if (head.single) begin
            written <= written + 1'b1;
            state   <= last ? S_DONE : (more ? S_WR1 : S_WAIT);
          end else begin
            state <= S_WR2;
          end
        end
        S_WR2: begin
          written <= written + 1'b1;
          state   <= last ? S_DONE : (more ? S_WR1 : S_WAIT);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_writeback.sv
// Bench for conv_writeback: vector table plus hand sequences, write scoreboard.
module tb_conv_writeback;

  logic       i_clk, i_rst, i_start;
  logic [9:0] i_total_pairs;
  logic [2:0] i_shift;
  logic       i_relu_en, i_valid, o_ready;
  logic [15:0] i_sum1, i_sum2;
  logic [9:0] i_dest_address1, i_dest_address2;
  logic       i_single, o_wr_en;
  logic [9:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_busy, o_done;

  conv_writeback dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_total_pairs(i_total_pairs),
    .i_shift(i_shift), .i_relu_en(i_relu_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_sum1(i_sum1), .i_sum2(i_sum2), .i_dest_address1(i_dest_address1),
    .i_dest_address2(i_dest_address2), .i_single(i_single), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_busy(o_busy), .o_done(o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    int         sh;
    bit         relu;
    int         s1;
    int         s2;
    bit         single;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  vec_t vecs[10];
  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every write must match the oldest outstanding expectation
  always @(negedge i_clk) begin : mon
    wr_t e;
    if (o_done === 1'b1) done_cnt++;
    if (o_wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%02h t=%0t", o_wr_addr, o_wr_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(o_wr_addr), 32'(e.a));
        chk("wr_data", 32'(o_wr_data), 32'(e.d));
      end
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_wr(input int a, input logic [7:0] d);
    wr_t w;
    w.a = 10'(a);
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic start_job(input int total, input int sh, input bit relu);
    i_total_pairs = 10'(total);
    i_shift       = 3'(sh);
    i_relu_en     = relu;
    i_start       = 1'b1;
    tick();
    i_start       = 1'b0;
  endtask

  task automatic drive_pair(input int s1, input int s2, input int a1, input int a2, input bit single);
    i_sum1          = 16'(s1);
    i_sum2          = 16'(s2);
    i_dest_address1 = 10'(a1);
    i_dest_address2 = 10'(a2);
    i_single        = single;
  endtask

  // Offer one pair until accepted; expectations queued at the handshake
  task automatic send_pair(input int s1, input int s2, input int a1, input int a2,
                           input bit single, input logic [7:0] e1, input logic [7:0] e2);
    bit ok;
    ok = 1'b0;
    drive_pair(s1, s2, a1, a2, single);
    i_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge i_clk);
      if (o_ready) begin
        ok = 1'b1;
        expect_wr(a1, e1);
        if (!single) expect_wr(a2, e2);
      end
      tick();
    end
    i_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge i_clk);
      if (o_done) got = 1'b1;
      else tick();
    end
    chk("done_seen", 32'(got), 1);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    tick();
    @(negedge i_clk);
    chk("done_one_cycle", 32'(o_done), 0);
    chk("idle_after_done", 32'(o_busy), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int w0, d0, idx, stall_acc, extra;
    vecs[0] = '{0, 0, 5,     -3,     0, 8'h05, 8'hFD};
    vecs[1] = '{2, 0, 6,     -6,     0, 8'h02, 8'hFF};
    vecs[2] = '{2, 0, 1000,  -1000,  0, 8'h7F, 8'h80};
    vecs[3] = '{0, 1, -7,    9,      0, 8'h00, 8'h09};
    vecs[4] = '{0, 0, 200,   -129,   0, 8'h7F, 8'h80};
    vecs[5] = '{1, 0, 7,     -7,     0, 8'h04, 8'hFD};
    vecs[6] = '{7, 0, 32767, -32768, 0, 8'h7F, 8'h80};
    vecs[7] = '{3, 1, -5,    12,     0, 8'h00, 8'h02};
    vecs[8] = '{0, 0, 127,   -128,   0, 8'h7F, 8'h80};
    vecs[9] = '{4, 0, 24,    0,      1, 8'h02, 8'h00};

    i_rst = 1'b1; i_start = 1'b0; i_total_pairs = '0; i_shift = '0; i_relu_en = 1'b0;
    i_valid = 1'b0; drive_pair(0, 0, 0, 0, 0);
    repeat (3) tick();
    @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_wr_en", 32'(o_wr_en), 0);
    chk("rst_wr_addr", 32'(o_wr_addr), 0);
    chk("rst_wr_data", 32'(o_wr_data), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    i_rst = 1'b0;
    tick();

    // Basic pair with exact cycle timing and bus hold afterwards
    start_job(1, 0, 0);
    @(negedge i_clk);
    chk("b_busy", 32'(o_busy), 1);
    chk("b_ready", 32'(o_ready), 1);
    chk("b_idle_wr", 32'(o_wr_en), 0);
    tick();
    send_pair(5, -3, 10, 12, 0, 8'h05, 8'hFD);
    @(negedge i_clk);
    chk("b_wr1_en", 32'(o_wr_en), 1);
    chk("b_wr1_addr", 32'(o_wr_addr), 10);
    chk("b_ready_at_total", 32'(o_ready), 0);
    tick();
    @(negedge i_clk);
    chk("b_wr2_en", 32'(o_wr_en), 1);
    chk("b_wr2_data", 32'(o_wr_data), 32'h0FD);
    tick();
    @(negedge i_clk);
    chk("b_done", 32'(o_done), 1);
    chk("b_done_no_wr", 32'(o_wr_en), 0);
    chk("b_hold_addr", 32'(o_wr_addr), 12);
    chk("b_hold_data", 32'(o_wr_data), 32'h0FD);
    tick();
    @(negedge i_clk);
    chk("b_done_pulse", 32'(o_done), 0);
    chk("b_idle", 32'(o_busy), 0);
    tick();

    // Requantize table, one single-pair job per vector
    for (int i = 0; i < 10; i++) begin
      start_job(1, vecs[i].sh, vecs[i].relu);
      send_pair(vecs[i].s1, vecs[i].s2, 20 + 4*i, 22 + 4*i, vecs[i].single, vecs[i].e1, vecs[i].e2);
      wait_done(20);
    end

    // Single last pair: three writes total
    w0 = wr_cnt;
    start_job(2, 0, 0);
    send_pair(11, 22, 100, 101, 0, 8'h0B, 8'h16);
    send_pair(33, 44, 102, 103, 1, 8'h21, 8'h00);
    wait_done(30);
    chk("single_write_count", wr_cnt - w0, 3);

    // Zero-length job: done the cycle after i_start is taken, no writes
    w0 = wr_cnt;
    start_job(0, 0, 0);
    @(negedge i_clk);
    chk("zero_done", 32'(o_done), 1);
    chk("zero_no_wr", 32'(o_wr_en), 0);
    chk("zero_no_ready", 32'(o_ready), 0);
    tick();
    @(negedge i_clk);
    chk("zero_done_pulse", 32'(o_done), 0);
    chk("zero_idle", 32'(o_busy), 0);
    tick();
    chk("zero_write_count", wr_cnt - w0, 0);

    // Backpressure: valid held high, eight pairs then an extra one
    d0 = done_cnt;
    start_job(8, 0, 0);
    idx = 0; stall_acc = -1; extra = 0;
    drive_pair(0, 0, 200, 201, 0);
    i_valid = 1'b1;
    for (int c = 0; c < 80 && idx < 8; c++) begin
      @(negedge i_clk);
      if (o_ready) begin
        expect_wr(200 + 2*idx, 8'(3*idx));
        expect_wr(201 + 2*idx, 8'(-idx));
        idx++;
      end else if (stall_acc < 0) begin
        stall_acc = idx;
      end
      tick();
      drive_pair(3*idx, -idx, 200 + 2*idx, 201 + 2*idx, 0);
    end
    chk("bp_all_accepted", idx, 8);
    chk("bp_first_stall_acc", stall_acc, 6);
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      if (o_ready) extra++;
      tick();
    end
    i_valid = 1'b0;
    chk("bp_ninth_refused", extra, 0);
    chk("bp_done_count", done_cnt - d0, 1);
    chk("bp_queue_drained", exp_q.size(), 0);
    chk("bp_idle", 32'(o_busy), 0);
    exp_q.delete();

    // Reset mid-job after two writes
    start_job(4, 0, 0);
    w0 = wr_cnt; d0 = done_cnt;
    send_pair(1, 2, 300, 301, 0, 8'h01, 8'h02);
    send_pair(3, 4, 302, 303, 0, 8'h03, 8'h04);
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      #1;
      if (wr_cnt - w0 >= 2) break;
      tick();
    end
    chk("rm_two_writes", wr_cnt - w0, 2);
    i_rst = 1'b1;
    tick();
    @(negedge i_clk);
    chk("rm_wr_en", 32'(o_wr_en), 0);
    chk("rm_busy", 32'(o_busy), 0);
    chk("rm_ready", 32'(o_ready), 0);
    exp_q.delete();
    i_rst = 1'b0;
    repeat (5) tick();
    chk("rm_no_more_writes", wr_cnt - w0, 2);
    chk("rm_no_done", done_cnt - d0, 0);
    start_job(1, 2, 0);
    send_pair(40, -40, 400, 401, 0, 8'h0A, 8'hF6);
    wait_done(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
